mem_access_aligner: RTL and testbench

Parametrised load/store alignment unit in the memory-access path of the pipeline. It takes one scalar load or store request per transaction and converts it into byte-lane-aligned bus beats with byte masks. A request that crosses a bus-word boundary is split into two sequential beats. Load data from one or both beats is reassembled and sign- or zero-extended before it is returned to the pipeline.

---
 rtl/mem_align_pkg.sv | 35 +++
 rtl/mem_lane_shift.sv | 48 ++++
 rtl/mem_access_aligner.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_aligner.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_align_pkg.sv
// Shared types and size helpers for the load/store alignment unit.
package mem_align_pkg;

  typedef enum logic [1:0] {
    MS_B = 2'd0,
    MS_H = 2'd1,
    MS_W = 2'd2,
    MS_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } align_state_t;

  // Number of bytes touched by an access of the given size.
  function automatic int unsigned size_bytes(input mem_size_t size);
    return 32'd1 << size;
  endfunction

  // Right-justified byte mask covering an access of the given size.
  function automatic logic [7:0] size_fmask(input mem_size_t size);
    logic [7:0] m;
    unique case (size)
      MS_B:    m = 8'h01;
      MS_H:    m = 8'h03;
      MS_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_shift.sv
// Byte-lane steering for one bus beat: shifts store data and mask into lanes and
// moves read data from lanes back to the right-justified assembly position.
module mem_lane_shift
  import mem_align_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  mem_size_t                 size_i,
  input  logic                      beat1_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           rdata_i,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN/8-1:0]         wmask_o,
  output logic [XLEN-1:0]           rdata_o
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  logic [OFFW:0] hi_lanes;
  logic [7:0]    fmask;

  // Beat 1 carries the bytes that spill past the word, so it shifts by NB-off lanes.
  assign hi_lanes = (OFFW+1)'(NB) - {1'b0, off_i};
  assign fmask    = size_fmask(size_i);

  // Data shifts in the direction of the selected beat.
  always_comb begin
    if (beat1_i) begin
      wdata_o = wdata_i >> {hi_lanes, 3'b000};
      rdata_o = rdata_i << {hi_lanes, 3'b000};
    end else begin
      wdata_o = wdata_i << {off_i, 3'b000};
      rdata_o = rdata_i >> {off_i, 3'b000};
    end
  end

  // Lane l of the beat holds access byte (l - off) or (l + NB - off).
  always_comb begin
    int idx;
    wmask_o = '0;
    for (int l = 0; l < int'(NB); l++) begin
      idx = beat1_i ? (l + int'(NB) - int'(off_i)) : (l - int'(off_i));
      wmask_o[l] = (idx >= 0 && idx < 8) ? fmask[idx[2:0]] : 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_aligner.sv
// Load/store alignment unit: turns one scalar request into one or two aligned bus
// beats and returns the reassembled, extended load data.
module mem_access_aligner
  import mem_align_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wmask,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_illegal
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  align_state_t    state_q, state_d;
  logic            is_store_q, is_store_d;
  mem_size_t       size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] asm_q, asm_d;
  logic            cross_q, cross_d;
  logic            misaligned_q, misaligned_d;
  logic            illegal_q, illegal_d;

  logic [OFFW-1:0] req_off;
  logic            req_cross;
  logic            req_illegal;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sh_wdata;
  logic [XLEN-1:0] sh_rdata;
  logic [NB-1:0]   sh_wmask;
  logic [XLEN-1:0] ext_rdata;

  assign req_off     = req_addr[OFFW-1:0];
  assign req_cross   = (32'(req_off) + size_bytes(mem_size_t'(req_size))) > NB;
  assign req_illegal = (req_size == 2'd3) && (XLEN == 32);
  assign base        = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

  mem_lane_shift #(
    .XLEN(XLEN)
  ) u_lane_shift (
    .off_i   (addr_q[OFFW-1:0]),
    .size_i  (size_q),
    .beat1_i (state_q == BEAT1),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .wdata_o (sh_wdata),
    .wmask_o (sh_wmask),
    .rdata_o (sh_rdata)
  );

  // Truncate the assembled load to the access size, then sign- or zero-extend.
  always_comb begin
    int   nbits;
    logic fill;
    nbits = 8 * int'(size_bytes(size_q));
    if (nbits > int'(XLEN)) nbits = int'(XLEN);
    fill = !unsigned_q && asm_q[nbits-1];
    for (int i = 0; i < int'(XLEN); i++) begin
      ext_rdata[i] = (i < nbits) ? asm_q[i] : fill;
    end
  end

  // Next-state logic: request latch, beat sequencing and load assembly.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    cross_d      = cross_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d   = req_is_store;
          size_d       = mem_size_t'(req_size);
          unsigned_d   = req_unsigned;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          asm_d        = '0;
          cross_d      = req_cross;
          misaligned_d = 1'b0;
          illegal_d    = 1'b0;
          if (req_illegal) begin
            illegal_d = 1'b1;
            state_d   = RESP;
          end else if (req_cross && !ALLOW_MISALIGNED) begin
            misaligned_d = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          if (!is_store_q) asm_d = sh_rdata;
          state_d = cross_q ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          if (!is_store_q) asm_d = asm_q | sh_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          misaligned_d = 1'b0;
          illegal_d    = 1'b0;
          state_d      = IDLE;
        end
      end
    endcase
  end

  // Outputs decode purely from flopped state, so they hold steady across stalls.
  always_comb begin
    bus_valid = (state_q == BEAT0) || (state_q == BEAT1);
    bus_we    = bus_valid && is_store_q;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wmask = '0;
    if (bus_valid) begin
      bus_addr  = (state_q == BEAT1) ? (base + XLEN'(NB)) : base;
      bus_wdata = sh_wdata;
      bus_wmask = sh_wmask;
    end
    req_ready       = rst_l && (state_q == IDLE);
    resp_valid      = (state_q == RESP);
    resp_misaligned = resp_valid && misaligned_q;
    resp_illegal    = resp_valid && illegal_q;
    resp_rdata      = (resp_valid && !is_store_q && !misaligned_q && !illegal_q) ? ext_rdata : '0;
  end

  // State and request registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      size_q       <= MS_B;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      cross_q      <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      cross_q      <= cross_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mem_access_aligner.sv
// Bench for mem_access_aligner (XLEN=32): directed vector table, randomized
// transactions against a byte-level reference model, and stall/reset sequences.
module tb_mem_access_aligner;

  logic        clk;
  logic        rst_l;
  logic        req_valid, req_valid_na;
  logic        req_ready, req_ready_na;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        bus_valid, bus_valid_na;
  logic        bus_ready;
  logic        bus_we, bus_we_na;
  logic [31:0] bus_addr, bus_addr_na, bus_wdata, bus_wdata_na;
  logic [3:0]  bus_wmask, bus_wmask_na;
  logic [31:0] bus_rdata;
  logic        resp_valid, resp_valid_na;
  logic        resp_ready;
  logic [31:0] resp_rdata, resp_rdata_na;
  logic        resp_misaligned, resp_misaligned_na;
  logic        resp_illegal, resp_illegal_na;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_aligner #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal)
  );

  mem_access_aligner #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid_na), .req_ready(req_ready_na), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .bus_valid(bus_valid_na), .bus_ready(bus_ready), .bus_we(bus_we_na),
    .bus_addr(bus_addr_na), .bus_wdata(bus_wdata_na), .bus_wmask(bus_wmask_na),
    .bus_rdata(bus_rdata),
    .resp_valid(resp_valid_na), .resp_ready(resp_ready), .resp_rdata(resp_rdata_na),
    .resp_misaligned(resp_misaligned_na), .resp_illegal(resp_illegal_na)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0][31:0] addr;
    logic [1:0][3:0]  mask;
    logic [1:0][31:0] wdata;
    logic [1:0]       we;
    int               nbeats;
    int               resp_cyc;
    logic [31:0]      rdata;
    logic             mis;
    logic             ill;
  } obs_t;

  typedef struct {
    logic st; logic [1:0] sz; logic uns;
    logic [31:0] a; logic [31:0] wd; logic [31:0] rd0; logic [31:0] rd1;
    int nb;
    logic [31:0] a0; logic [3:0] m0; logic [31:0] w0;
    logic [31:0] a1; logic [3:0] m1; logic [31:0] w1;
    logic [31:0] rdata; logic ill;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the access byte by byte; beat k lane l holds access byte 4k+l-off.
  function automatic obs_t model(input logic st, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd0, input logic [31:0] rd1);
    obs_t        o;
    int          bytes, off, j, p;
    logic [31:0] word;
    o = '0;
    if (sz == 2'd3) begin
      o.resp_cyc = 1;
      o.ill      = 1'b1;
      return o;
    end
    bytes      = 1 << sz;
    off        = int'(a[1:0]);
    o.nbeats   = (off + bytes > 4) ? 2 : 1;
    o.resp_cyc = o.nbeats + 1;
    for (int k = 0; k < o.nbeats; k++) begin
      o.addr[k] = {a[31:2], 2'b00} + 32'(4 * k);
      o.we[k]   = st;
      for (int l = 0; l < 4; l++) begin
        j = 4 * k + l - off;
        if (j >= 0 && j < 4) o.wdata[k][8*l +: 8] = wd[8*j +: 8];
        if (j >= 0 && j < bytes) o.mask[k][l] = 1'b1;
      end
    end
    if (!st) begin
      for (int b = 0; b < 4; b++) begin
        if (b < bytes) begin
          p    = off + b;
          word = (p < 4) ? rd0 : rd1;
          o.rdata[8*b +: 8] = word[8*(p % 4) +: 8];
        end else begin
          o.rdata[8*b +: 8] = (!uns && o.rdata[8*bytes-1]) ? 8'hFF : 8'h00;
        end
      end
    end
    return o;
  endfunction

  // Issue one request with both readies high and record what the DUT does.
  task automatic do_txn(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd0, input logic [31:0] rd1, output obs_t o);
    int cyc;
    o = '0;
    bus_ready    = 1'b1;
    resp_ready   = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    step();
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wdata = ~wd;
    cyc = 1;
    while (!resp_valid && cyc < 10) begin
      if (bus_valid) begin
        if (o.nbeats < 2) begin
          o.addr[o.nbeats]  = bus_addr;
          o.mask[o.nbeats]  = bus_wmask;
          o.wdata[o.nbeats] = bus_wdata;
          o.we[o.nbeats]    = bus_we;
          bus_rdata = (o.nbeats == 0) ? rd0 : rd1;
        end
        o.nbeats = o.nbeats + 1;
      end
      step();
      cyc++;
    end
    o.resp_cyc = cyc;
    o.rdata    = resp_rdata;
    o.mis      = resp_misaligned;
    o.ill      = resp_illegal;
    bus_rdata  = 32'hDEAD_BEEF;
    step();
  endtask

  task automatic cmp_obs(input string tag, input obs_t g, input obs_t e);
    chk({tag, ".beats"}, 64'(g.nbeats), 64'(e.nbeats));
    chk({tag, ".resp_cyc"}, 64'(g.resp_cyc), 64'(e.resp_cyc));
    for (int k = 0; k < e.nbeats && k < 2; k++) begin
      chk($sformatf("%s.addr%0d", tag, k), 64'(g.addr[k]), 64'(e.addr[k]));
      chk($sformatf("%s.mask%0d", tag, k), 64'(g.mask[k]), 64'(e.mask[k]));
      chk($sformatf("%s.wdata%0d", tag, k), 64'(g.wdata[k]), 64'(e.wdata[k]));
      chk($sformatf("%s.we%0d", tag, k), 64'(g.we[k]), 64'(e.we[k]));
    end
    chk({tag, ".rdata"}, 64'(g.rdata), 64'(e.rdata));
    chk({tag, ".misaligned"}, 64'(g.mis), 64'(e.mis));
    chk({tag, ".illegal"}, 64'(g.ill), 64'(e.ill));
  endtask

  initial begin
    obs_t        got, exp;
    logic        st, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd0, rd1;

    //          st    sz    uns   addr         wdata        rd0          rd1          nb
    //          a0           m0       w0           a1           m1       w1           rdata        ill
    vecs[0] = '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 32'h0, 1,
                32'h1000, 4'b1000, 32'hAB00_0000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 1'b0, 32'h1002, 32'h1122_3344, 32'h0, 32'h0, 2,
                32'h1000, 4'b1100, 32'h3344_0000, 32'h1004, 4'b0011, 32'h0000_1122, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 2'd1, 1'b0, 32'h2003, 32'h0, 32'h7F00_0000, 32'h0000_00FF, 2,
                32'h2000, 4'b1000, 32'h0, 32'h2004, 4'b0001, 32'h0, 32'hFFFF_FF7F, 1'b0};
    vecs[3] = '{1'b0, 2'd1, 1'b1, 32'h2003, 32'h0, 32'h7F00_0000, 32'h0000_00FF, 2,
                32'h2000, 4'b1000, 32'h0, 32'h2004, 4'b0001, 32'h0, 32'h0000_FF7F, 1'b0};
    vecs[4] = '{1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'h8000_0001, 32'h0, 1,
                32'h3000, 4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h8000_0001, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 1'b0, 32'h3001, 32'h0, 32'h0000_8000, 32'h0, 1,
                32'h3000, 4'b0010, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 1'b0, 32'h3002, 32'h0000_BEEF, 32'h0, 32'h0, 1,
                32'h3000, 4'b1100, 32'hBEEF_0000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[7] = '{1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h1234_5678, 32'h0, 0,
                32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 1'b1, 32'h4003, 32'h0, 32'h9A00_0000, 32'h0, 1,
                32'h4000, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0000_009A, 1'b0};

    rst_l        = 1'b0;
    req_valid    = 1'b0;
    req_valid_na = 1'b0;
    req_is_store = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    bus_ready    = 1'b1;
    bus_rdata    = '0;
    resp_ready   = 1'b1;

    // Reset state.
    #2;
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.bus_valid", 64'(bus_valid), 64'd0);
    chk("rst.bus_addr", 64'(bus_addr), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst.na_req_ready", 64'(req_ready_na), 64'd0);
    step();
    step();
    rst_l = 1'b1;
    #1;
    chk("rst_rel.req_ready", 64'(req_ready), 64'd1);
    chk("rst_rel.na_req_ready", 64'(req_ready_na), 64'd1);
    step();

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
             vecs[i].rd0, vecs[i].rd1, got);
      exp          = '0;
      exp.nbeats   = vecs[i].nb;
      exp.resp_cyc = (vecs[i].nb == 0) ? 1 : vecs[i].nb + 1;
      exp.addr[0]  = vecs[i].a0;
      exp.mask[0]  = vecs[i].m0;
      exp.wdata[0] = vecs[i].w0;
      exp.we[0]    = vecs[i].st;
      exp.addr[1]  = vecs[i].a1;
      exp.mask[1]  = vecs[i].m1;
      exp.wdata[1] = vecs[i].w1;
      exp.we[1]    = vecs[i].st;
      exp.rdata    = vecs[i].rdata;
      exp.ill      = vecs[i].ill;
      cmp_obs($sformatf("vec%0d", i), got, exp);
    end

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      st  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = $urandom;
      wd  = $urandom;
      rd0 = $urandom;
      rd1 = $urandom;
      do_txn(st, sz, uns, a, wd, rd0, rd1, got);
      cmp_obs($sformatf("rnd%0d", i), got, model(st, sz, uns, a, wd, rd0, rd1));
    end

    // Crossing access rejected when misaligned accesses are disallowed.
    req_is_store = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h1001;
    req_wdata    = 32'h1122_3344;
    req_valid_na = 1'b1;
    step();
    req_valid_na = 1'b0;
    chk("na.c1.bus_valid", 64'(bus_valid_na), 64'd0);
    chk("na.c1.resp_valid", 64'(resp_valid_na), 64'd1);
    chk("na.c1.resp_misaligned", 64'(resp_misaligned_na), 64'd1);
    chk("na.c1.resp_illegal", 64'(resp_illegal_na), 64'd0);
    chk("na.c1.resp_rdata", 64'(resp_rdata_na), 64'd0);
    chk("na.c1.req_ready", 64'(req_ready_na), 64'd0);
    chk("na.c1.main_idle", 64'(req_ready), 64'd1);
    step();
    chk("na.c2.bus_valid", 64'(bus_valid_na), 64'd0);
    chk("na.c2.resp_valid", 64'(resp_valid_na), 64'd0);
    chk("na.c2.resp_misaligned", 64'(resp_misaligned_na), 64'd0);
    chk("na.c2.req_ready", 64'(req_ready_na), 64'd1);

    // Crossing load with 3 bus stall cycles in BEAT0 and 2 resp stall cycles.
    bus_ready    = 1'b0;
    resp_ready   = 1'b0;
    req_is_store = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h1002;
    req_wdata    = 32'hCAFE_F00D;
    req_valid    = 1'b1;
    step();
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus_ready = 1'b1;
      bus_rdata = (c == 4) ? 32'h5566_7788 : 32'hDEAD_BEEF;
      chk($sformatf("stall.c%0d.bus_valid", c), 64'(bus_valid), 64'd1);
      chk($sformatf("stall.c%0d.bus_addr", c), 64'(bus_addr), 64'h1000);
      chk($sformatf("stall.c%0d.bus_wmask", c), 64'(bus_wmask), 64'b1100);
      chk($sformatf("stall.c%0d.bus_wdata", c), 64'(bus_wdata), 64'hF00D_0000);
      chk($sformatf("stall.c%0d.req_ready", c), 64'(req_ready), 64'd0);
      step();
    end
    bus_rdata = 32'h1122_3344;
    chk("stall.c5.bus_addr", 64'(bus_addr), 64'h1004);
    chk("stall.c5.bus_wmask", 64'(bus_wmask), 64'b0011);
    chk("stall.c5.bus_wdata", 64'(bus_wdata), 64'h0000_CAFE);
    step();
    bus_rdata = 32'hDEAD_BEEF;
    for (int c = 6; c <= 8; c++) begin
      if (c == 8) resp_ready = 1'b1;
      chk($sformatf("stall.c%0d.resp_valid", c), 64'(resp_valid), 64'd1);
      chk($sformatf("stall.c%0d.resp_rdata", c), 64'(resp_rdata), 64'h3344_5566);
      chk($sformatf("stall.c%0d.bus_valid", c), 64'(bus_valid), 64'd0);
      chk($sformatf("stall.c%0d.req_ready", c), 64'(req_ready), 64'd0);
      step();
    end
    chk("stall.c9.req_ready", 64'(req_ready), 64'd1);
    chk("stall.c9.resp_valid", 64'(resp_valid), 64'd0);

    // Reset pulsed during BEAT1 of a crossing store.
    bus_ready    = 1'b1;
    resp_ready   = 1'b1;
    req_is_store = 1'b1;
    req_size     = 2'd2;
    req_addr     = 32'h1002;
    req_wdata    = 32'h1122_3344;
    req_valid    = 1'b1;
    step();
    req_valid = 1'b0;
    chk("rstmid.c1.bus_addr", 64'(bus_addr), 64'h1000);
    step();
    bus_ready = 1'b0;
    chk("rstmid.c2.bus_addr", 64'(bus_addr), 64'h1004);
    chk("rstmid.c2.bus_we", 64'(bus_we), 64'd1);
    rst_l = 1'b0;
    #1;
    chk("rstmid.async.bus_valid", 64'(bus_valid), 64'd0);
    chk("rstmid.async.bus_we", 64'(bus_we), 64'd0);
    chk("rstmid.async.bus_addr", 64'(bus_addr), 64'd0);
    chk("rstmid.async.bus_wmask", 64'(bus_wmask), 64'd0);
    chk("rstmid.async.bus_wdata", 64'(bus_wdata), 64'd0);
    chk("rstmid.async.resp_valid", 64'(resp_valid), 64'd0);
    chk("rstmid.async.req_ready", 64'(req_ready), 64'd0);
    bus_ready = 1'b1;
    step();
    step();
    chk("rstmid.held.bus_valid", 64'(bus_valid), 64'd0);
    rst_l = 1'b1;
    #1;
    chk("rstmid.rel.req_ready", 64'(req_ready), 64'd1);
    chk("rstmid.rel.bus_valid", 64'(bus_valid), 64'd0);
    step();
    chk("rstmid.after.bus_valid", 64'(bus_valid), 64'd0);
    chk("rstmid.after.resp_valid", 64'(resp_valid), 64'd0);

    // Normal operation resumes after the abort.
    do_txn(1'b1, 2'd0, 1'b0, 32'h5001, 32'h0000_005A, 32'h0, 32'h0, got);
    cmp_obs("post_rst", got, model(1'b1, 2'd0, 1'b0, 32'h5001, 32'h0000_005A, 32'h0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
